// File: rtl/fetch_unit.sv
// In-order IF stage: credit-limited pipelined fetch, BUF_DEPTH-entry PC/inst buffer, redirect flush, sticky exit.
// Accept->if_valid = memory latency + 1; ID backpressure holds the head stable and throttles requests via credit.
module fetch_unit #(
  parameter int unsigned         WORD_LEN   = 32,
  parameter logic [WORD_LEN-1:0] START_ADDR = '0,
  parameter int unsigned         PC_STEP    = 4,
  parameter int unsigned         BUF_DEPTH  = 4,
  parameter logic [WORD_LEN-1:0] EXIT_INST  = 32'h34333231
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  input  logic                redirect_valid,
  input  logic [WORD_LEN-1:0] redirect_pc,
  output logic                if_valid,
  output logic [WORD_LEN-1:0] if_inst,
  output logic [WORD_LEN-1:0] if_pc,
  input  logic                id_ready,
  output logic                exit
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [CW:0]         DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [WORD_LEN-1:0] STEP    = WORD_LEN'(PC_STEP);

  logic [WORD_LEN-1:0] fetch_pc, resp_pc;
  logic [WORD_LEN-1:0] buf_inst [BUF_DEPTH];
  logic [WORD_LEN-1:0] buf_pc   [BUF_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count, inflight, discard;
  logic [CW:0]         occupancy;
  logic                started;
  logic                transfer, exit_hit, redir, accept, rsp_take, push, pop;

  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign imem_req  = started && !exit && !redirect_valid && (occupancy < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  assign if_valid  = !exit && (count != '0);
  assign if_inst   = if_valid ? buf_inst[rd_ptr] : '0;
  assign if_pc     = if_valid ? buf_pc[rd_ptr]   : '0;

  assign transfer  = if_valid && id_ready;
  assign exit_hit  = transfer && (if_inst == EXIT_INST);
  // An exit seen this cycle wins over a simultaneous redirect.
  assign redir     = redirect_valid && !exit && !exit_hit;

  // Responses only retire against an outstanding request; stray rvalid is ignored.
  assign rsp_take  = imem_rvalid && (inflight != '0);
  assign push      = rsp_take && (discard == '0) && !exit && !redir;
  assign pop       = transfer && !redir;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started  <= 1'b0;
      fetch_pc <= START_ADDR;
      resp_pc  <= START_ADDR;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      exit     <= 1'b0;
    end else begin
      started  <= 1'b1;
      inflight <= inflight + CW'(accept) - CW'(rsp_take);
      if (exit_hit) exit <= 1'b1;
      if (redir) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Everything still outstanding after this cycle's response belongs to the old path.
        discard  <= inflight - CW'(rsp_take);
      end else begin
        if (accept) fetch_pc <= fetch_pc + STEP;
        if (rsp_take && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + STEP;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
